start_pulse_gen: RTL and testbench
==================================

START_PULSE_GEN -- requirements
Module: start_pulse_gen

Interface
REQ-001 Parameter NUM_CH, default 1: number of start outputs, 1..32.
REQ-002 Parameter DLY_W, default 16: width of delay and gap counters.
REQ-003 Parameter PW_W, default 8: width of pulse-width field.
REQ-004 Parameter RPT_W, default 8: width of repeat-count field and pulse counter.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rstn  in  1  asynchronous, active-low reset; assertion immediate, deassertion synchronous to clk via internal 2-flop synchroniser.
REQ-007 arm  in  1  single-cycle request to start a sequence.
REQ-008 abort  in  1  single-cycle request to cancel a sequence.
REQ-009 axil_done  in  1  level; register-configuration-complete qualifier.
REQ-010 dly  in  DLY_W  cycles between axil_done sample and first pulse.
REQ-011 pulse_w  in  PW_W  pulse high time in cycles; 0 treated as 1.
REQ-012 gap  in  DLY_W  low time between pulses in cycles; 0 treated as 1.
REQ-013 rpt  in  RPT_W  number of pulses; 0 treated as 1.
REQ-014 ch_mask  in  NUM_CH  per-channel enable for start.
REQ-015 start  out  NUM_CH  registered start pulses.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 seq_done  out  1  one-cycle pulse on normal sequence completion.
REQ-018 pulse_cnt  out  RPT_W  pulses issued in current/last sequence.

Function
REQ-019 FSM states SHALL be IDLE, WAIT_DONE, DELAY, PULSE, GAP, FINISH.
REQ-020 IDLE -> WAIT_DONE on arm sampled high; dly, pulse_w, gap, rpt, ch_mask latched on that edge; pulse_cnt cleared.
REQ-021 arm while busy=1 SHALL be ignored; latched config SHALL not change mid-sequence.
REQ-022 WAIT_DONE -> DELAY on axil_done sampled high; axil_done already high at arm edge SHALL be sampled on the next edge.
REQ-023 First start assertion SHALL occur dly+1 cycles after the edge sampling axil_done high (dly=0 -> next cycle).
REQ-024 PULSE: start = latched ch_mask for exactly max(pulse_w,1) cycles, else start = 0.
REQ-025 pulse_cnt SHALL increment on the last cycle of each PULSE; saturation not required (max rpt = 2^RPT_W-1).
REQ-026 After PULSE: if pulse_cnt reaches max(rpt,1) -> FINISH, else -> GAP for max(gap,1) cycles -> PULSE.
REQ-027 FINISH: seq_done high exactly one cycle, busy high that cycle, then IDLE.
REQ-028 abort sampled high in any non-IDLE state SHALL force IDLE on that edge, start=0, no seq_done; pulse_cnt holds.
REQ-029 abort and arm in same cycle in IDLE: abort wins, stays IDLE.
REQ-030 ch_mask=0: sequence timing unchanged, start stays 0, seq_done still issued.
REQ-031 axil_done deasserting after being sampled SHALL not affect a running sequence.

Reset
REQ-032 On rstn low: state IDLE, start=0, busy=0, seq_done=0, pulse_cnt=0, all counters and latched config 0.
REQ-033 Reset asserted mid-sequence SHALL clear start within the same cycle (asynchronous), no seq_done.
REQ-034 After rstn high, arm SHALL be accepted no earlier than the third clk edge (synchroniser latency).

Verification
REQ-035 NUM_CH=1, dly=5, pulse_w=1, rpt=1, axil_done high 20 cycles after arm -> start high 1 cycle, 6 cycles after axil_done sample edge; seq_done 1 cycle later; pulse_cnt=1.
REQ-036 NUM_CH=4, ch_mask=4'b1010, dly=0, pulse_w=3, gap=2, rpt=3 -> start=4'b1010 three times, 3 high/2 low, busy low after seq_done, pulse_cnt=3.
REQ-037 pulse_w=0, gap=0, rpt=0 -> exactly one 1-cycle pulse, identical to pulse_w=1, rpt=1.
REQ-038 abort during second PULSE of rpt=4 -> start=0 next cycle, IDLE, no seq_done, pulse_cnt=1; new arm then runs a full sequence.
REQ-039 rstn low for 2 cycles during DELAY -> all outputs 0 immediately; arm on first edge after rstn high ignored, arm on third edge accepted.
REQ-040 arm pulsed during GAP with different config -> running sequence timing and mask unchanged.

Source files
------------

// File: rtl/start_pulse_gen.sv
// Armed start-pulse sequencer: waits for configuration-done, delays, then emits
// a programmable train of masked start pulses with gaps, abortable at any time.
module start_pulse_gen #(
    parameter int unsigned NUM_CH = 1,
    parameter int unsigned DLY_W  = 16,
    parameter int unsigned PW_W   = 8,
    parameter int unsigned RPT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              arm,
    input  logic              abort,
    input  logic              axil_done,
    input  logic [DLY_W-1:0]  dly,
    input  logic [PW_W-1:0]   pulse_w,
    input  logic [DLY_W-1:0]  gap,
    input  logic [RPT_W-1:0]  rpt,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] start,
    output logic              busy,
    output logic              seq_done,
    output logic [RPT_W-1:0]  pulse_cnt
);

    localparam int unsigned CNT_W = (DLY_W > PW_W) ? DLY_W : PW_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_FINISH
    } state_e;

    logic rst_meta_q;
    logic rst_sync_q;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [DLY_W-1:0]   dly_q,       dly_d;
    logic [PW_W-1:0]    pw_q,        pw_d;
    logic [DLY_W-1:0]   gap_q,       gap_d;
    logic [RPT_W-1:0]   rpt_q,       rpt_d;
    logic [NUM_CH-1:0]  mask_q,      mask_d;
    logic [RPT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [NUM_CH-1:0]  start_q,     start_d;
    logic               busy_q,      busy_d;
    logic               seq_done_q,  seq_done_d;

    logic [CNT_W-1:0]   pw_last;
    logic [CNT_W-1:0]   gap_last;
    logic [RPT_W-1:0]   rpt_eff;
    logic [RPT_W-1:0]   cnt_inc;

    // Reset assertion is immediate; release is delayed two edges into the clock domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Zero-valued pulse width, gap and repeat count behave as one.
    assign pw_last  = (pw_q  == '0) ? '0 : CNT_W'(pw_q  - PW_W'(1));
    assign gap_last = (gap_q == '0) ? '0 : CNT_W'(gap_q - DLY_W'(1));
    assign rpt_eff  = (rpt_q == '0) ? RPT_W'(1) : rpt_q;
    assign cnt_inc  = pulse_cnt_q + RPT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        pw_d        = pw_q;
        gap_d       = gap_q;
        rpt_d       = rpt_q;
        mask_d      = mask_q;
        pulse_cnt_d = pulse_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    state_d     = S_WAIT_DONE;
                    dly_d       = dly;
                    pw_d        = pulse_w;
                    gap_d       = gap;
                    rpt_d       = rpt;
                    mask_d      = ch_mask;
                    pulse_cnt_d = '0;
                    cnt_d       = '0;
                end
            end
            S_WAIT_DONE: begin
                if (axil_done) begin
                    state_d = S_DELAY;
                    cnt_d   = CNT_W'(dly_q);
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = pw_last;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    pulse_cnt_d = cnt_inc;
                    if (cnt_inc == rpt_eff) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = gap_last;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = pw_last;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE and freezes the pulse count.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            pulse_cnt_d = pulse_cnt_q;
        end

        start_d    = (state_d == S_PULSE) ? mask_q : '0;
        busy_d     = (state_d != S_IDLE);
        seq_done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dly_q       <= '0;
            pw_q        <= '0;
            gap_q       <= '0;
            rpt_q       <= '0;
            mask_q      <= '0;
            pulse_cnt_q <= '0;
            start_q     <= '0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            pw_q        <= pw_d;
            gap_q       <= gap_d;
            rpt_q       <= rpt_d;
            mask_q      <= mask_d;
            pulse_cnt_q <= pulse_cnt_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign seq_done  = seq_done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_start_pulse_gen.sv
// Scoreboard bench for start_pulse_gen: expected start/done/busy events are queued
// by the stimulus and popped by a monitor as the DUT produces them.
module tb_start_pulse_gen;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DLY_W  = 16;
    localparam int unsigned PW_W   = 8;
    localparam int unsigned RPT_W  = 8;

    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_BUSY  = 2;

    logic              clk       = 1'b0;
    logic              rstn      = 1'b0;
    logic              arm       = 1'b0;
    logic              abort     = 1'b0;
    logic              axil_done = 1'b0;
    logic [DLY_W-1:0]  dly       = '0;
    logic [PW_W-1:0]   pulse_w   = '0;
    logic [DLY_W-1:0]  gap       = '0;
    logic [RPT_W-1:0]  rpt       = '0;
    logic [NUM_CH-1:0] ch_mask   = '0;
    logic [NUM_CH-1:0] start;
    logic              busy;
    logic              seq_done;
    logic [RPT_W-1:0]  pulse_cnt;

    start_pulse_gen #(
        .NUM_CH (NUM_CH),
        .DLY_W  (DLY_W),
        .PW_W   (PW_W),
        .RPT_W  (RPT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .arm       (arm),
        .abort     (abort),
        .axil_done (axil_done),
        .dly       (dly),
        .pulse_w   (pulse_w),
        .gap       (gap),
        .rpt       (rpt),
        .ch_mask   (ch_mask),
        .start     (start),
        .busy      (busy),
        .seq_done  (seq_done),
        .pulse_cnt (pulse_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    bit  mon_en  = 1'b0;
    logic [NUM_CH-1:0] start_prev = '0;
    logic              busy_prev  = 1'b0;

    function automatic void push_ev(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int k, input int v);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d got=%0d required=none", k, cyc, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                n_fail++;
                $display("FAIL event got kind=%0d cyc=%0d val=%0d required kind=%0d cyc=%0d val=%0d",
                         k, cyc, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // Monitor: every output transition (and each seq_done cycle) must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (start !== start_prev) check_ev(EV_START, int'(start));
            if (seq_done === 1'b1)    check_ev(EV_DONE, int'(pulse_cnt));
            if (busy !== busy_prev)   check_ev(EV_BUSY, int'(busy));
            start_prev = start;
            busy_prev  = busy;
        end
    end

    // Arm at the current negedge, release axil_done after wait_n cycles (or pre-assert
    // it), queue the full expected event train, and optionally re-arm during the first gap.
    task automatic run_seq(input int d, input int pw, input int g, input int r,
                           input logic [NUM_CH-1:0] m, input int wait_n,
                           input bit pre, input bit gap_arm);
        int c, a, t, pwe, ge, re, f, xarm;
        c       = cyc;
        dly     = DLY_W'(d);
        pulse_w = PW_W'(pw);
        gap     = DLY_W'(g);
        rpt     = RPT_W'(r);
        ch_mask = m;
        arm     = 1'b1;
        if (pre) axil_done = 1'b1;
        push_ev(EV_BUSY, c + 1, 1);
        @(negedge clk);
        arm     = 1'b0;
        dly     = DLY_W'(77);
        pulse_w = PW_W'(9);
        gap     = DLY_W'(11);
        rpt     = RPT_W'(7);
        ch_mask = 4'hF;
        if (!pre) begin
            repeat (wait_n - 1) @(negedge clk);
            axil_done = 1'b1;
        end
        a   = cyc;
        pwe = (pw == 0) ? 1 : pw;
        ge  = (g == 0) ? 1 : g;
        re  = (r == 0) ? 1 : r;
        t   = a + d + 2;
        f   = t;
        for (int i = 0; i < re; i++) begin
            if (m != '0) begin
                push_ev(EV_START, t, int'(m));
                push_ev(EV_START, t + pwe, 0);
            end
            if (i == re - 1) f = t + pwe;
            else             t = t + pwe + ge;
        end
        push_ev(EV_DONE, f, re);
        push_ev(EV_BUSY, f + 1, 0);
        xarm = gap_arm ? (a + d + 2 + pwe) : -1;
        while (cyc < f + 2) begin
            @(negedge clk);
            axil_done = 1'b0;
            arm       = (cyc == xarm);
            if (cyc == xarm) begin
                dly     = DLY_W'(0);
                pulse_w = PW_W'(1);
                gap     = DLY_W'(1);
                rpt     = RPT_W'(1);
                ch_mask = 4'b1001;
            end
        end
        arm = 1'b0;
    endtask

    // rpt=4 sequence aborted during the first cycle of its second pulse.
    task automatic run_abort();
        int c, t1, t2;
        c       = cyc;
        dly     = DLY_W'(1);
        pulse_w = PW_W'(3);
        gap     = DLY_W'(2);
        rpt     = RPT_W'(4);
        ch_mask = 4'b1000;
        arm     = 1'b1;
        push_ev(EV_BUSY, c + 1, 1);
        @(negedge clk);
        arm       = 1'b0;
        axil_done = 1'b1;
        t1 = c + 4;
        t2 = t1 + 5;
        push_ev(EV_START, t1, 8);
        push_ev(EV_START, t1 + 3, 0);
        push_ev(EV_START, t2, 8);
        push_ev(EV_START, t2 + 1, 0);
        push_ev(EV_BUSY, t2 + 1, 0);
        @(negedge clk);
        axil_done = 1'b0;
        for (int k = 0; k < 50 && cyc < t2; k++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pulse_cnt", int'(pulse_cnt), 1);
        check("abort_busy", int'(busy), 0);
    endtask

    // Reset asserted asynchronously during the second pulse, then arm timing after release.
    task automatic run_reset();
        int c;
        c       = cyc;
        dly     = DLY_W'(2);
        pulse_w = PW_W'(2);
        gap     = DLY_W'(1);
        rpt     = RPT_W'(3);
        ch_mask = 4'b0111;
        arm     = 1'b1;
        push_ev(EV_BUSY, c + 1, 1);
        @(negedge clk);
        arm       = 1'b0;
        axil_done = 1'b1;
        push_ev(EV_START, c + 5, 7);
        push_ev(EV_START, c + 7, 0);
        push_ev(EV_START, c + 8, 7);
        push_ev(EV_START, c + 9, 0);
        push_ev(EV_BUSY, c + 9, 0);
        @(negedge clk);
        axil_done = 1'b0;
        for (int k = 0; k < 50 && cyc < c + 8; k++) @(negedge clk);
        check("pre_reset_pulse_cnt", int'(pulse_cnt), 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_start_async", int'(start), 0);
        check("rst_busy_async", int'(busy), 0);
        check("rst_done_async", int'(seq_done), 0);
        check("rst_cnt_async", int'(pulse_cnt), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        arm  = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        check("arm_first_edge_ignored", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_start", int'(start), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(seq_done), 0);
        check("reset_cnt", int'(pulse_cnt), 0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        start_prev = start;
        busy_prev  = busy;
        mon_en     = 1'b1;

        run_seq(5, 1, 0, 1, 4'b0001, 20, 1'b0, 1'b0);
        check("single_pulse_cnt", int'(pulse_cnt), 1);
        run_seq(0, 3, 2, 3, 4'b1010, 0, 1'b1, 1'b0);
        check("train_cnt", int'(pulse_cnt), 3);
        check("train_busy", int'(busy), 0);
        run_seq(2, 0, 0, 0, 4'b1111, 3, 1'b0, 1'b0);
        check("zero_cfg_cnt", int'(pulse_cnt), 1);
        run_seq(1, 2, 1, 2, 4'b0000, 2, 1'b0, 1'b0);
        check("mask0_cnt", int'(pulse_cnt), 2);
        run_seq(0, 2, 4, 2, 4'b0110, 1, 1'b0, 1'b1);
        check("gap_arm_cnt", int'(pulse_cnt), 2);
        run_abort();

        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_arm_abort_busy", int'(busy), 0);

        run_seq(3, 2, 3, 2, 4'b0101, 1, 1'b0, 1'b0);
        check("rearm_cnt", int'(pulse_cnt), 2);
        run_reset();
        run_seq(0, 1, 1, 2, 4'b0011, 1, 1'b0, 1'b0);
        check("post_reset_cnt", int'(pulse_cnt), 2);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
